// File: rtl/mem_access_unit.sv
// M-stage data-memory access unit: one load/store per instruction over a req/ack bus.
// Define MEM_ALIGN_EXC_EN to trap misaligned word/half accesses instead of issuing them.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              m_valid,
    output logic [31:0]       m_mout,
    output logic [1:0]        m_addr10,
    output logic [1:0]        m_mem2reg,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              exc_adel,
    output logic              exc_ades
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUS  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [1:0] T_WORD = 2'b01;
    localparam logic [1:0] T_HALF = 2'b10;
    localparam logic [1:0] T_BYTE = 2'b11;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        type_q, type_d;
    logic [1:0]        addr10_q, addr10_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mout_q, mout_d;
    logic              exc_q, exc_d;

    logic              req_act;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_calc;
    logic              misalign;

    assign req_act = req_valid && (req_type != 2'b00);

    always_comb begin
        be_calc    = 4'b0000;
        wdata_calc = req_wdata;
        unique case (req_type)
            T_WORD: begin
                be_calc    = 4'b1111;
                wdata_calc = req_wdata;
            end
            T_HALF: begin
                be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{req_wdata[15:0]}};
            end
            T_BYTE: begin
                be_calc    = 4'b0001 << req_addr[1:0];
                wdata_calc = {4{req_wdata[7:0]}};
            end
            default: begin
                be_calc    = 4'b0000;
                wdata_calc = req_wdata;
            end
        endcase
    end

`ifdef MEM_ALIGN_EXC_EN
    always_comb begin
        misalign = 1'b0;
        if (req_type == T_WORD)
            misalign = (req_addr[1:0] != 2'b00);
        else if (req_type == T_HALF)
            misalign = req_addr[0];
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        type_d   = type_q;
        addr10_d = addr10_q;
        baddr_d  = baddr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        mout_d   = mout_q;
        exc_d    = exc_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_act) begin
                    we_d     = req_we;
                    type_d   = req_type;
                    addr10_d = req_addr[1:0];
                    baddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    be_d     = be_calc;
                    wdata_d  = wdata_calc;
                    mout_d   = 32'h0;
                    exc_d    = misalign;
                    state_d  = misalign ? S_DONE : S_BUS;
                end
            end
            S_BUS: begin
                if (bus_ack) begin
                    if (!we_q)
                        mout_d = bus_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                exc_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            type_q   <= 2'b00;
            addr10_q <= 2'b00;
            baddr_q  <= '0;
            be_q     <= 4'b0000;
            wdata_q  <= 32'h0;
            mout_q   <= 32'h0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            type_q   <= type_d;
            addr10_q <= addr10_d;
            baddr_q  <= baddr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            mout_q   <= mout_d;
            exc_q    <= exc_d;
        end
    end

    // The pipeline is released on the DONE cycle so it advances with m_valid.
    assign stall     = req_act && (state_q != S_DONE);
    assign m_valid   = (state_q == S_DONE) && !exc_q;
    assign m_mout    = mout_q;
    assign m_addr10  = addr10_q;
    assign m_mem2reg = type_q;
    assign bus_req   = (state_q == S_BUS);
    assign bus_we    = (state_q == S_BUS) && we_q;
    assign bus_addr  = baddr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

`ifdef MEM_ALIGN_EXC_EN
    assign exc_adel = (state_q == S_DONE) && exc_q && !we_q;
    assign exc_ades = (state_q == S_DONE) && exc_q && we_q;
`else
    assign exc_adel = 1'b0;
    assign exc_ades = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit.
// Covers loads, stores, lane enables, back-to-back ops, reset abort and alignment.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        m_valid;
    logic [31:0] m_mout;
    logic [1:0]  m_addr10;
    logic [1:0]  m_mem2reg;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        exc_adel;
    logic        exc_ades;

    int nvec = 0;
    int nerr = 0;

    int          o_lat, o_stalls, o_reqs, o_excl, o_excs, o_mv;
    logic        o_done, o_we;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_mout;
    logic [1:0]  o_a10, o_m2r;
    logic        seen;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .m_valid   (m_valid),
        .m_mout    (m_mout),
        .m_addr10  (m_addr10),
        .m_mem2reg (m_mem2reg),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request at posedge+1 and serve it; ack on BUS cycle ack_dly+1.
    task automatic run_op(input logic we, input logic [1:0] typ, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_dly,
                          input logic [31:0] rdata, input logic scramble);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = typ;
        req_addr  = addr;
        req_wdata = wdata;
        o_lat = 0; o_stalls = 0; o_reqs = 0; o_excl = 0; o_excs = 0; o_mv = 0;
        o_done = 1'b0;
        for (int cyc = 0; cyc < 50 && !o_done; cyc++) begin
            @(negedge clk);
            if (stall) o_stalls++;
            if (exc_adel) o_excl++;
            if (exc_ades) o_excs++;
            if (bus_req) begin
                o_reqs++;
                o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata; o_we = bus_we;
                bus_ack   = (o_reqs > ack_dly);
                bus_rdata = rdata;
            end else begin
                bus_ack = 1'b0;
            end
            if (m_valid || exc_adel || exc_ades) begin
                o_done = 1'b1;
                o_lat  = cyc;
                o_mv   = int'(m_valid);
                o_mout = m_mout; o_a10 = m_addr10; o_m2r = m_mem2reg;
            end
            @(posedge clk);
            #1;
            bus_ack   = 1'b0;
            bus_rdata = 32'h0;
            if (scramble && o_reqs >= 1 && !o_done) begin
                req_addr  = ~addr;
                req_wdata = ~wdata;
            end
        end
        check("op_done", {31'd0, o_done}, 32'd1);
    endtask

    task automatic end_op();
        req_valid = 1'b0;
        req_type  = 2'b00;
        @(negedge clk);
        check("mvalid_pulse", {31'd0, m_valid}, 32'd0);
        check("idle_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_type = 2'b00;
        req_addr = 32'h0; req_wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mvalid", {31'd0, m_valid}, 32'd0);
        check("rst_busreq", {31'd0, bus_req}, 32'd0);
        check("rst_buswe", {31'd0, bus_we}, 32'd0);
        check("rst_mout", m_mout, 32'h0);
        check("rst_busaddr", bus_addr, 32'h0);
        check("rst_be_a10_m2r", {24'd0, bus_be, m_addr10, m_mem2reg}, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_exc", {30'd0, exc_adel, exc_ades}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // lh with ack in first BUS cycle
        run_op(1'b0, 2'b10, 32'h0000_3002, 32'h0, 0, 32'h8001_7FFF, 1'b0);
        check("lh_lat", o_lat, 32'd2);
        check("lh_stalls", o_stalls, 32'd2);
        check("lh_reqs", o_reqs, 32'd1);
        check("lh_mout", o_mout, 32'h8001_7FFF);
        check("lh_a10", {30'd0, o_a10}, 32'd2);
        check("lh_m2r", {30'd0, o_m2r}, 32'd2);
        check("lh_be", {28'd0, o_be}, 32'hC);
        check("lh_we", {31'd0, o_we}, 32'd0);
        check("lh_addr", o_addr, 32'h0000_3000);
        end_op();

        // sw, ack on third BUS cycle, request inputs change while stalled
        run_op(1'b1, 2'b01, 32'h0000_1004, 32'hDEAD_BEEF, 2, 32'h5555_5555, 1'b1);
        check("sw_lat", o_lat, 32'd4);
        check("sw_stalls", o_stalls, 32'd4);
        check("sw_reqs", o_reqs, 32'd3);
        check("sw_be", {28'd0, o_be}, 32'hF);
        check("sw_addr", o_addr, 32'h0000_1004);
        check("sw_wdata", o_wdata, 32'hDEAD_BEEF);
        check("sw_we", {31'd0, o_we}, 32'd1);
        check("sw_mout", o_mout, 32'h0);
        end_op();

        // sb to lane 3
        run_op(1'b1, 2'b11, 32'h0000_2003, 32'h0000_00A5, 1, 32'h0, 1'b0);
        check("sb_be", {28'd0, o_be}, 32'h8);
        check("sb_wdata", o_wdata, 32'hA5A5_A5A5);
        check("sb_addr", o_addr, 32'h0000_2000);
        check("sb_a10_m2r", {28'd0, o_a10, o_m2r}, 32'hF);
        end_op();

        // sh to upper half
        run_op(1'b1, 2'b10, 32'h0000_2012, 32'hCAFE_1234, 0, 32'h0, 1'b0);
        check("sh_be", {28'd0, o_be}, 32'hC);
        check("sh_wdata", o_wdata, 32'h1234_1234);
        end_op();

        // lb lane 1
        run_op(1'b0, 2'b11, 32'h0000_0051, 32'h0, 0, 32'h1122_3344, 1'b0);
        check("lb_be", {28'd0, o_be}, 32'h2);
        check("lb_mout", o_mout, 32'h1122_3344);
        check("lb_a10_m2r", {28'd0, o_a10, o_m2r}, 32'h7);
        end_op();

        // back-to-back lw then sw, no idle gap from the pipeline
        run_op(1'b0, 2'b01, 32'h0000_0100, 32'h0, 1, 32'hA1B2_C3D4, 1'b0);
        check("b2b_lw_reqs", o_reqs, 32'd2);
        check("b2b_lw_mout", o_mout, 32'hA1B2_C3D4);
        run_op(1'b1, 2'b01, 32'h0000_0200, 32'h0BAD_F00D, 0, 32'h0, 1'b0);
        check("b2b_sw_lat", o_lat, 32'd2);
        check("b2b_sw_reqs", o_reqs, 32'd1);
        check("b2b_sw_addr", o_addr, 32'h0000_0200);
        check("b2b_sw_wdata", o_wdata, 32'h0BAD_F00D);
        end_op();

        // req_type 00: no stall, no bus cycle, no completion
        req_valid = 1'b1; req_type = 2'b00; req_we = 1'b0; req_addr = 32'h44;
        @(negedge clk);
        check("none_stall", {31'd0, stall}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | bus_req | m_valid | stall;
        end
        check("none_activity", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        // stray bus_ack while idle
        bus_ack = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | bus_req | m_valid;
        end
        check("stray_ack", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;
        bus_ack = 1'b0;

        // misaligned lw
        run_op(1'b0, 2'b01, 32'h0000_0006, 32'h0, 0, 32'h7766_5544, 1'b0);
`ifdef MEM_ALIGN_EXC_EN
        check("mis_reqs", o_reqs, 32'd0);
        check("mis_adel", o_excl, 32'd1);
        check("mis_ades", o_excs, 32'd0);
        check("mis_mvalid", o_mv, 32'd0);
`else
        check("mis_be", {28'd0, o_be}, 32'hF);
        check("mis_addr", o_addr, 32'h0000_0004);
        check("mis_mout", o_mout, 32'h7766_5544);
        check("mis_exc", o_excl + o_excs, 32'd0);
`endif
        end_op();

        // reset in BUS with no ack
        req_valid = 1'b1; req_we = 1'b0; req_type = 2'b01; req_addr = 32'h40;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_busreq_pre", {31'd0, bus_req}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid = 1'b0;
        req_type = 2'b00;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_busreq", {31'd0, bus_req}, 32'd0);
        check("abort_mvalid", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | m_valid | bus_req;
        end
        check("abort_quiet", {31'd0, seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
